// File: rtl/biu_pkg.sv
// Shared types and default widths for the BIU cache-line port and its upstream arbiters.
package biu_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int LINE_W_DEF = 512;

   typedef enum logic {
      MST_IC = 1'b0,
      MST_DC = 1'b1
   } mst_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RESP,
      ST_RESP
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; the master that did not win last time wins a tie.
module rr_arb2
   import biu_pkg::*;
(
   input  logic [1:0] req,
   input  mst_e       last_grant,
   output logic [1:0] gnt
);

   // Bit 0 is the icache, bit 1 the dcache; grant is one-hot or zero.
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last_grant == MST_IC) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates icache refills and dcache refills/writebacks onto the single BIU cache-line port,
// one transaction at a time, with a watchdog that turns a lost response into an error.
module l2_port_arbiter
   import biu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LINE_W  = LINE_W_DEF,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_req_vld_i,
   output logic              ic_req_rdy_o,
   input  logic [ADDR_W-1:0] ic_req_addr_i,
   output logic              ic_resp_vld_o,
   input  logic              ic_resp_rdy_i,
   output logic [LINE_W-1:0] ic_resp_rdata_o,
   output logic              ic_resp_err_o,
   input  logic              dc_req_vld_i,
   output logic              dc_req_rdy_o,
   input  logic              dc_req_rd_i,
   input  logic [ADDR_W-1:0] dc_req_addr_i,
   input  logic [LINE_W-1:0] dc_req_wdata_i,
   output logic              dc_resp_vld_o,
   input  logic              dc_resp_rdy_i,
   output logic [LINE_W-1:0] dc_resp_rdata_o,
   output logic              dc_resp_err_o,
   output logic              biu_req_vld_o,
   input  logic              biu_req_rdy_i,
   output logic              biu_req_rd_o,
   output logic [ADDR_W-1:0] biu_req_addr_o,
   output logic [LINE_W-1:0] biu_req_wdata_o,
   input  logic              biu_resp_vld_i,
   output logic              biu_resp_rdy_o,
   input  logic [LINE_W-1:0] biu_resp_rdata_i,
   input  logic              biu_resp_err_i
);

   // A disabled watchdog still needs a one-bit counter to keep the logic well-formed.
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [WD_W-1:0] WD_MAX  = '1;

   state_e            state_q, state_d;
   mst_e              owner_q, last_grant_q;
   logic              rd_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q, rdata_q;
   logic [WD_W-1:0]   wd_q;

   logic [1:0] gnt;
   logic       accept_ic, accept_dc, issue_done, timeout, resp_done;

   rr_arb2 u_rr_arb2 (
      .req        ({dc_req_vld_i, ic_req_vld_i}),
      .last_grant (last_grant_q),
      .gnt        (gnt)
   );

   always_comb begin
      state_d        = state_q;
      ic_req_rdy_o   = 1'b0;
      dc_req_rdy_o   = 1'b0;
      biu_req_vld_o  = 1'b0;
      biu_resp_rdy_o = 1'b0;
      ic_resp_vld_o  = 1'b0;
      dc_resp_vld_o  = 1'b0;
      accept_ic      = 1'b0;
      accept_dc      = 1'b0;
      issue_done     = 1'b0;
      timeout        = 1'b0;
      resp_done      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ic_req_rdy_o = gnt[0];
            dc_req_rdy_o = gnt[1];
            accept_ic    = ic_req_vld_i && gnt[0];
            accept_dc    = dc_req_vld_i && gnt[1];
            if (accept_ic || accept_dc) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            biu_req_vld_o = 1'b1;
            if (biu_req_rdy_i) begin
               issue_done = 1'b1;
               state_d    = ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            biu_resp_rdy_o = 1'b1;
            // A real response in the timeout cycle wins over the synthetic error.
            if (biu_resp_vld_i) begin
               state_d = ST_RESP;
            end else if (TIMEOUT != 0 && wd_q == WD_LAST) begin
               timeout = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            ic_resp_vld_o = (owner_q == MST_IC);
            dc_resp_vld_o = (owner_q == MST_DC);
            if ((owner_q == MST_IC && ic_resp_rdy_i) || (owner_q == MST_DC && dc_resp_rdy_i)) begin
               resp_done = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ic_resp_err_o   = (state_q == ST_RESP) && (owner_q == MST_IC) && err_q;
   assign dc_resp_err_o   = (state_q == ST_RESP) && (owner_q == MST_DC) && err_q;
   assign ic_resp_rdata_o = rdata_q;
   assign dc_resp_rdata_o = rdata_q;
   assign biu_req_rd_o    = rd_q;
   assign biu_req_addr_o  = addr_q;
   assign biu_req_wdata_o = wdata_q;

   // State and transaction registers; icache refills are always reads with no write data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= MST_IC;
         last_grant_q <= MST_DC;
         rd_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         wd_q         <= '0;
      end else begin
         state_q <= state_d;
         if (accept_ic) begin
            owner_q <= MST_IC;
            rd_q    <= 1'b1;
            addr_q  <= ic_req_addr_i;
            wdata_q <= '0;
         end else if (accept_dc) begin
            owner_q <= MST_DC;
            rd_q    <= dc_req_rd_i;
            addr_q  <= dc_req_addr_i;
            wdata_q <= dc_req_wdata_i;
         end
         if (issue_done) wd_q <= '0;
         if (state_q == ST_WAIT_RESP) begin
            if (biu_resp_vld_i) begin
               rdata_q <= biu_resp_rdata_i;
               err_q   <= biu_resp_err_i;
            end else if (timeout) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end else if (wd_q != WD_MAX) begin
               wd_q <= wd_q + WD_W'(1);
            end
         end
         if (resp_done) last_grant_q <= owner_q;
      end
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed testbench for l2_port_arbiter with a 16-cycle watchdog.
module tb_l2_port_arbiter;

   localparam int ADDR_W  = 64;
   localparam int LINE_W  = 512;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ic_req_vld_i, ic_req_rdy_o, ic_resp_vld_o, ic_resp_rdy_i, ic_resp_err_o;
   logic [ADDR_W-1:0] ic_req_addr_i;
   logic [LINE_W-1:0] ic_resp_rdata_o;
   logic              dc_req_vld_i, dc_req_rdy_o, dc_req_rd_i, dc_resp_vld_o, dc_resp_rdy_i, dc_resp_err_o;
   logic [ADDR_W-1:0] dc_req_addr_i;
   logic [LINE_W-1:0] dc_req_wdata_i, dc_resp_rdata_o;
   logic              biu_req_vld_o, biu_req_rdy_i, biu_req_rd_o, biu_resp_vld_i, biu_resp_rdy_o, biu_resp_err_i;
   logic [ADDR_W-1:0] biu_req_addr_o;
   logic [LINE_W-1:0] biu_req_wdata_o, biu_resp_rdata_i;

   int checks = 0;
   int errors = 0;

   l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req_vld_i(ic_req_vld_i), .ic_req_rdy_o(ic_req_rdy_o), .ic_req_addr_i(ic_req_addr_i),
      .ic_resp_vld_o(ic_resp_vld_o), .ic_resp_rdy_i(ic_resp_rdy_i),
      .ic_resp_rdata_o(ic_resp_rdata_o), .ic_resp_err_o(ic_resp_err_o),
      .dc_req_vld_i(dc_req_vld_i), .dc_req_rdy_o(dc_req_rdy_o), .dc_req_rd_i(dc_req_rd_i),
      .dc_req_addr_i(dc_req_addr_i), .dc_req_wdata_i(dc_req_wdata_i),
      .dc_resp_vld_o(dc_resp_vld_o), .dc_resp_rdy_i(dc_resp_rdy_i),
      .dc_resp_rdata_o(dc_resp_rdata_o), .dc_resp_err_o(dc_resp_err_o),
      .biu_req_vld_o(biu_req_vld_o), .biu_req_rdy_i(biu_req_rdy_i), .biu_req_rd_o(biu_req_rd_o),
      .biu_req_addr_o(biu_req_addr_o), .biu_req_wdata_o(biu_req_wdata_o),
      .biu_resp_vld_i(biu_resp_vld_i), .biu_resp_rdy_o(biu_resp_rdy_o),
      .biu_resp_rdata_i(biu_resp_rdata_i), .biu_resp_err_i(biu_resp_err_i)
   );

   always #5 clk = ~clk;

   // Outputs are sampled and inputs driven 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ic_req_vld_i = 0; ic_req_addr_i = '0; ic_resp_rdy_i = 0;
      dc_req_vld_i = 0; dc_req_rd_i = 0; dc_req_addr_i = '0; dc_req_wdata_i = '0; dc_resp_rdy_i = 0;
      biu_req_rdy_i = 0; biu_resp_vld_i = 0; biu_resp_rdata_i = '0; biu_resp_err_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      #1;
      checks++;
      if ({ic_req_rdy_o, dc_req_rdy_o, biu_req_vld_o, biu_resp_rdy_o, ic_resp_vld_o, dc_resp_vld_o,
           ic_resp_err_o, dc_resp_err_o} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000000", {ic_req_rdy_o, dc_req_rdy_o, biu_req_vld_o,
                  biu_resp_rdy_o, ic_resp_vld_o, dc_resp_vld_o, ic_resp_err_o, dc_resp_err_o});
      end
      checks++;
      if (biu_req_addr_o !== '0 || biu_req_wdata_o !== '0 || biu_req_rd_o !== 1'b0 || ic_resp_rdata_o !== '0) begin
         errors++;
         $display("FAIL reset_data: got addr %h rd %b expected all zero", biu_req_addr_o, biu_req_rd_o);
      end
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   task automatic test_ic_read();
      ic_req_vld_i = 1; ic_req_addr_i = 64'h8000_0040;
      #1;
      checks++;
      if (ic_req_rdy_o !== 1'b1 || dc_req_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL ic_read_grant: got ic %b dc %b expected ic 1 dc 0", ic_req_rdy_o, dc_req_rdy_o);
      end
      tick();
      ic_req_vld_i = 0;
      checks++;
      if (biu_req_vld_o !== 1'b1 || biu_req_rd_o !== 1'b1 || biu_req_addr_o !== 64'h8000_0040) begin
         errors++;
         $display("FAIL ic_read_issue: got vld %b rd %b addr %h expected 1 1 8000_0040",
                  biu_req_vld_o, biu_req_rd_o, biu_req_addr_o);
      end
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      checks++;
      if (biu_resp_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL ic_read_resp_rdy: got %b expected 1", biu_resp_rdy_o);
      end
      tick();
      tick();
      biu_resp_vld_i = 1; biu_resp_rdata_i = {64{8'hA5}}; biu_resp_err_i = 0;
      tick();
      biu_resp_vld_i = 0; biu_resp_rdata_i = '0;
      checks++;
      if (ic_resp_vld_o !== 1'b1 || ic_resp_err_o !== 1'b0 || ic_resp_rdata_o !== {64{8'hA5}} || dc_resp_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL ic_read_resp: got vld %b err %b dcvld %b data %h expected 1 0 0 a5..",
                  ic_resp_vld_o, ic_resp_err_o, dc_resp_vld_o, ic_resp_rdata_o[63:0]);
      end
      ic_resp_rdy_i = 1;
      tick();
      ic_resp_rdy_i = 0;
      checks++;
      if (ic_resp_vld_o !== 1'b0 || dc_resp_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL ic_read_done: got ic %b dc %b expected 0 0", ic_resp_vld_o, dc_resp_vld_o);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ic_req_vld_i = 1; ic_req_addr_i = 64'h40;
      dc_req_vld_i = 1; dc_req_rd_i = 1; dc_req_addr_i = 64'h2000;
      #1;
      checks++;
      if (ic_req_rdy_o !== 1'b1 || dc_req_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL tie_first: got ic %b dc %b expected 1 0", ic_req_rdy_o, dc_req_rdy_o);
      end
      tick();
      ic_req_vld_i = 0;
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      biu_resp_vld_i = 1; biu_resp_rdata_i = {64{8'h3C}};
      tick();
      biu_resp_vld_i = 0;
      checks++;
      if (dc_req_rdy_o !== 1'b0 || ic_resp_vld_o !== 1'b1) begin
         errors++;
         $display("FAIL tie_dc_held: got dcrdy %b icvld %b expected 0 1", dc_req_rdy_o, ic_resp_vld_o);
      end
      ic_resp_rdy_i = 1;
      tick();
      ic_resp_rdy_i = 0;
      ic_req_vld_i = 1;
      #1;
      checks++;
      if (dc_req_rdy_o !== 1'b1 || ic_req_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL tie_second: got dc %b ic %b expected 1 0", dc_req_rdy_o, ic_req_rdy_o);
      end
      tick();
      ic_req_vld_i = 0; dc_req_vld_i = 0;
      checks++;
      if (biu_req_vld_o !== 1'b1 || biu_req_addr_o !== 64'h2000 || biu_req_rd_o !== 1'b1) begin
         errors++;
         $display("FAIL tie_dc_issue: got vld %b addr %h rd %b expected 1 2000 1",
                  biu_req_vld_o, biu_req_addr_o, biu_req_rd_o);
      end
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      biu_resp_vld_i = 1; biu_resp_rdata_i = {64{8'h77}};
      tick();
      biu_resp_vld_i = 0;
      checks++;
      if (dc_resp_vld_o !== 1'b1 || ic_resp_vld_o !== 1'b0 || dc_resp_rdata_o !== {64{8'h77}}) begin
         errors++;
         $display("FAIL tie_dc_resp: got dc %b ic %b expected 1 0", dc_resp_vld_o, ic_resp_vld_o);
      end
      dc_resp_rdy_i = 1;
      tick();
      dc_resp_rdy_i = 0;
   endtask

   task automatic test_writeback_stall();
      logic [LINE_W-1:0] wd;
      wd = {8{64'h0123_4567_89AB_CDEF}};
      dc_req_vld_i = 1; dc_req_rd_i = 0; dc_req_addr_i = 64'h1000; dc_req_wdata_i = wd;
      tick();
      dc_req_vld_i = 0; dc_req_wdata_i = '0; dc_req_addr_i = '0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (biu_req_vld_o !== 1'b1 || biu_req_rd_o !== 1'b0 || biu_req_addr_o !== 64'h1000 || biu_req_wdata_o !== wd) begin
            errors++;
            $display("FAIL wb_stable cycle %0d: got vld %b rd %b addr %h expected 1 0 1000",
                     c, biu_req_vld_o, biu_req_rd_o, biu_req_addr_o);
         end
         tick();
      end
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      biu_resp_vld_i = 1; biu_resp_err_i = 0; biu_resp_rdata_i = '0;
      tick();
      biu_resp_vld_i = 0;
      checks++;
      if (dc_resp_vld_o !== 1'b1 || dc_resp_err_o !== 1'b0 || ic_resp_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL wb_resp: got vld %b err %b icvld %b expected 1 0 0", dc_resp_vld_o, dc_resp_err_o, ic_resp_vld_o);
      end
      dc_resp_rdy_i = 1;
      tick();
      dc_resp_rdy_i = 0;
   endtask

   task automatic test_dc_error();
      dc_req_vld_i = 1; dc_req_rd_i = 1; dc_req_addr_i = 64'h3000;
      tick();
      dc_req_vld_i = 0;
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      biu_resp_vld_i = 1; biu_resp_err_i = 1; biu_resp_rdata_i = {64{8'h5A}};
      tick();
      biu_resp_vld_i = 0; biu_resp_err_i = 0;
      checks++;
      if (dc_resp_vld_o !== 1'b1 || dc_resp_err_o !== 1'b1 || dc_resp_rdata_o !== {64{8'h5A}} || ic_resp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL dc_err_resp: got vld %b err %b icerr %b expected 1 1 0", dc_resp_vld_o, dc_resp_err_o, ic_resp_err_o);
      end
      dc_resp_rdy_i = 1;
      tick();
      dc_resp_rdy_i = 0;
      // With last grant on dcache, a tie must go to icache; then both drop before the edge.
      ic_req_vld_i = 1; dc_req_vld_i = 1;
      #1;
      checks++;
      if (ic_req_rdy_o !== 1'b1 || dc_req_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL dc_err_last_grant: got ic %b dc %b expected 1 0", ic_req_rdy_o, dc_req_rdy_o);
      end
      ic_req_vld_i = 0; dc_req_vld_i = 0;
      tick();
      checks++;
      if (biu_req_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL drop_vld: got biu vld %b expected 0", biu_req_vld_o);
      end
   endtask

   task automatic test_timeout();
      int waits;
      ic_req_vld_i = 1; ic_req_addr_i = 64'h9000;
      tick();
      ic_req_vld_i = 0;
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      waits = 0;
      while (biu_resp_rdy_o === 1'b1 && waits < 40) begin
         waits++;
         tick();
      end
      checks++;
      if (waits != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d expected %0d", waits, TIMEOUT);
      end
      checks++;
      if (ic_resp_vld_o !== 1'b1 || ic_resp_err_o !== 1'b1 || ic_resp_rdata_o !== '0) begin
         errors++;
         $display("FAIL timeout_resp: got vld %b err %b expected 1 1 with zero data", ic_resp_vld_o, ic_resp_err_o);
      end
      biu_resp_vld_i = 1; biu_resp_err_i = 0; biu_resp_rdata_i = {64{8'hFF}};
      #1;
      checks++;
      if (biu_resp_rdy_o !== 1'b0) begin
         errors++;
         $display("FAIL late_resp_rdy: got %b expected 0", biu_resp_rdy_o);
      end
      tick();
      biu_resp_vld_i = 0; biu_resp_rdata_i = '0;
      checks++;
      if (ic_resp_err_o !== 1'b1 || ic_resp_rdata_o !== '0) begin
         errors++;
         $display("FAIL late_resp_ignored: got err %b data %h expected 1 0", ic_resp_err_o, ic_resp_rdata_o[63:0]);
      end
      ic_resp_rdy_i = 1;
      tick();
      ic_resp_rdy_i = 0;
   endtask

   task automatic test_reset_mid();
      ic_req_vld_i = 1; ic_req_addr_i = 64'hA000;
      tick();
      ic_req_vld_i = 0;
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      checks++;
      if (biu_resp_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_in_wait: got %b expected 1", biu_resp_rdy_o);
      end
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({biu_req_vld_o, biu_resp_rdy_o, ic_req_rdy_o, dc_req_rdy_o, ic_resp_vld_o, dc_resp_vld_o} !== 6'b0) begin
         errors++;
         $display("FAIL mid_reset_async: got %b expected 000000", {biu_req_vld_o, biu_resp_rdy_o,
                  ic_req_rdy_o, dc_req_rdy_o, ic_resp_vld_o, dc_resp_vld_o});
      end
      tick();
      rst_n = 1;
      tick();
      ic_req_vld_i = 1; ic_req_addr_i = 64'hB040;
      #1;
      checks++;
      if (ic_req_rdy_o !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_grant: got %b expected 1", ic_req_rdy_o);
      end
      tick();
      ic_req_vld_i = 0;
      checks++;
      if (biu_req_vld_o !== 1'b1 || biu_req_addr_o !== 64'hB040) begin
         errors++;
         $display("FAIL post_reset_issue: got vld %b addr %h expected 1 b040", biu_req_vld_o, biu_req_addr_o);
      end
      biu_req_rdy_i = 1;
      tick();
      biu_req_rdy_i = 0;
      biu_resp_vld_i = 1; biu_resp_rdata_i = {64{8'h11}};
      tick();
      biu_resp_vld_i = 0;
      checks++;
      if (ic_resp_vld_o !== 1'b1 || ic_resp_rdata_o !== {64{8'h11}} || ic_resp_err_o !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_resp: got vld %b err %b expected 1 0", ic_resp_vld_o, ic_resp_err_o);
      end
      ic_resp_rdy_i = 1;
      tick();
      ic_resp_rdy_i = 0;
   endtask

   initial begin
      test_reset();
      test_ic_read();
      test_back_to_back();
      test_writeback_stall();
      test_dc_error();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] time limit reached");
   end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Upstream neighbour of the bus interface unit's cache-line port; arbitrates line requests from the instruction cache (read-only refills) and the data cache (refills and writebacks) onto that single cache-line request/response port.
- One transaction in flight; responses are routed back to the owning master.
- A watchdog converts a lost response into an error response.

Parameters:
- ADDR_W, 64, request address width
- LINE_W, 512, cache line width in bits
- TIMEOUT, 4096, max cycles in WAIT_RESP before a synthetic error response; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_req_vld_i  in  1  icache refill request valid
- ic_req_rdy_o  out  1  icache request accepted
- ic_req_addr_i  in  ADDR_W  icache line address
- ic_resp_vld_o  out  1  icache response valid
- ic_resp_rdy_i  in  1  icache response ready
- ic_resp_rdata_o  out  LINE_W  icache line data
- ic_resp_err_o  out  1  icache error
- dc_req_vld_i  in  1  dcache request valid
- dc_req_rdy_o  out  1  dcache request accepted
- dc_req_rd_i  in  1  1=refill, 0=writeback
- dc_req_addr_i  in  ADDR_W  dcache line address
- dc_req_wdata_i  in  LINE_W  writeback data
- dc_resp_vld_o / dc_resp_rdy_i / dc_resp_rdata_o / dc_resp_err_o  out/in/out/out  1/1/LINE_W/1  dcache response, same semantics as icache
- biu_req_vld_o  out  1  request valid to BIU cache port
- biu_req_rdy_i  in  1  BIU ready
- biu_req_rd_o  out  1  read=1 / write=0
- biu_req_addr_o  out  ADDR_W  address
- biu_req_wdata_o  out  LINE_W  write data
- biu_resp_vld_i  in  1  BIU response valid
- biu_resp_rdy_o  out  1  response ready to BIU
- biu_resp_rdata_i  in  LINE_W  response data
- biu_resp_err_i  in  1  response error

Behaviour:
- Reset values:
  - all *_vld_o, *_rdy_o and *_err_o = 0
  - data and address outputs = 0
  - state = IDLE
  - last_grant = dcache (icache therefore wins the first tie)
  - watchdog counter = 0
- State machine: IDLE -> ISSUE -> WAIT_RESP -> RESP -> IDLE.
- IDLE:
  - grant is combinational. If only one master has vld, that master wins. If both have vld, the master not equal to last_grant wins (round-robin).
  - The granted master's req_rdy_o = 1, combinationally. It is 0 in every other state and 0 for the loser.
  - On the vld&&rdy handshake, register owner, rd, addr and wdata. For icache, rd=1 and wdata=0. Then go to ISSUE.
- ISSUE:
  - biu_req_vld_o = 1, driven from registers; outputs stay stable until biu_req_rdy_i.
  - On handshake, go to WAIT_RESP and clear the watchdog.
- WAIT_RESP:
  - biu_resp_rdy_o = 1.
  - On biu_resp_vld_i, latch rdata and err, then go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 (if TIMEOUT != 0), latch rdata=0 and err=1, then go to RESP.
  - A response arriving in the same cycle as the timeout takes priority over the timeout.
- RESP:
  - Drive the owner's resp_vld_o = 1 with the latched rdata and err. The other master's resp_vld_o stays 0.
  - Hold until the owner's resp_rdy_i, then set last_grant = owner and go to IDLE.
  - The next grant can happen in the cycle immediately after RESP completes.
- Latency:
  - request handshake to biu_req_vld_o: 1 cycle
  - biu_resp_vld_i to master resp_vld_o: 1 cycle
  - minimum round trip with zero-wait BIU: 4 cycles
- Writebacks return a response (data ignored by the dcache); err is forwarded.
- A late BIU response arriving after a timeout (state != WAIT_RESP) is ignored, since biu_resp_rdy_o is 0.
- A master dropping vld before it is granted is legal. Nothing is latched.
- Reset mid-transaction: async return to IDLE, all valids deasserted immediately, the in-flight transaction is discarded.
- Width rules: the watchdog is $clog2(TIMEOUT+1) bits and saturates, never wraps.

Decomposition:
- Shared package (biu_pkg):
  - master-id enum (MST_IC=0, MST_DC=1)
  - state enum
  - LINE_W and ADDR_W defaults, shared with the BIU
- Sub-module rr_arb2: 2-input round-robin grant from request bits and last_grant. Purely combinational, reused later for uncache arbitration.

Test Plan:
- Only ic requests addr 0x8000_0040, BIU returns rdata=all 0xA5 after 3 cycles -> biu_req_rd_o=1 and addr 0x8000_0040; ic_resp_vld_o with 0xA5 pattern, err=0; dc_resp_vld_o never set.
- ic and dc both request in the same cycle after reset -> ic granted first. dc_req_rdy_o stays 0 until ic's response completes, then dc is granted the next IDLE cycle.
- dc writeback with addr 0x1000 and wdata pattern 0x0123..., biu_req_rdy_i held low 5 cycles -> biu outputs stable all 5 cycles; on completion dc_resp_vld_o=1, err=0.
- BIU returns err=1 for a dc refill -> dc_resp_err_o=1 with rdata forwarded; last_grant = dc.
- TIMEOUT=16, BIU never responds -> exactly 16 WAIT_RESP cycles, then the owner gets resp_vld=1 and err=1. A BIU response arriving later is not accepted.
- Assert rst_n low while in WAIT_RESP -> all valids and readys 0 asynchronously; after release, the next ic request is accepted normally.
